test_rand_delay_queue: RTL



---
 rtl/test_rand_delay_pkg.sv | 10 +
 rtl/vc_Lfsr32.sv | 17 +
 rtl/test_rand_delay_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/test_rand_delay_pkg.sv
// Shared constants for the random-delay queue: the LFSR feedback polynomial,
// the delay-mode encodings and the width of each per-entry delay counter.
package test_rand_delay_pkg;

  localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
  localparam logic        MODE_RANDOM = 1'b0;
  localparam logic        MODE_FIXED  = 1'b1;
  localparam int          CNT_W       = 32;

endpackage

// File: rtl/vc_Lfsr32.sv
// 32-bit right-shifting Galois LFSR. It free-runs every cycle and supplies
// the pseudo-random value used to pick per-message delays.
module vc_Lfsr32 import test_rand_delay_pkg::*; #(
  parameter logic [31:0] p_seed = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] out
);

  // Advance one step per cycle: shift right and fold the polynomial in when bit 0 falls out.
  always_ff @(posedge clk) begin
    if (reset) out <= p_seed;
    else       out <= {1'b0, out[31:1]} ^ (out[0] ? LFSR_POLY : 32'h0);
  end

endmodule

// File: rtl/test_rand_delay_queue.sv
// In-order FIFO in which every entry carries its own delay counter. A message
// becomes visible at the output only once it is the head and its counter has
// drained to zero. Delays are zero, fixed (max_delay) or random (lfsr % max_delay).
// Optional statistics counters are built when TEST_RAND_DELAY_QUEUE_STATS_EN
// is defined; otherwise the stat ports read as zero.
module test_rand_delay_queue import test_rand_delay_pkg::*; #(
  parameter int          p_msg_nbits = 1,
  parameter int          p_depth     = 4,
  parameter logic [31:0] p_seed      = 32'hACE1_0001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic                   mode,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic [31:0]            stat_xfers,
  output logic [31:0]            stat_stalls
);

  localparam int AW = $clog2(p_depth);

  logic [p_msg_nbits-1:0] msg_q [p_depth];
  logic [CNT_W-1:0]       cnt_q [p_depth];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic [31:0]            lfsr;
  logic [CNT_W-1:0]       load_delay;
  logic                   full;
  logic                   empty;
  logic                   enq;
  logic                   deq;

  vc_Lfsr32 #(.p_seed(p_seed)) lfsr_u (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr)
  );

  assign full    = (count == (AW+1)'(p_depth));
  assign empty   = (count == '0);
  assign in_rdy  = !reset && !full;
  assign out_val = !reset && !empty && (cnt_q[rd_ptr] == '0);
  assign out_msg = out_val ? msg_q[rd_ptr] : 'x;
  assign enq     = in_val && in_rdy;
  assign deq     = out_val && out_rdy;

  // Pick the delay an arriving message will carry; only sampled on enqueue.
  always_comb begin
    load_delay = '0;
    if (max_delay != '0) begin
      case (mode)
        MODE_FIXED:  load_delay = max_delay;
        MODE_RANDOM: load_delay = lfsr % max_delay;
      endcase
    end
  end

  // Message storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (enq) msg_q[wr_ptr] <= in_msg;
  end

  // Per-entry delay counters: load on enqueue, otherwise count down to zero regardless of position.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_depth; i++) begin
      if (reset)                           cnt_q[i] <= '0;
      else if (enq && wr_ptr == AW'(i))    cnt_q[i] <= load_delay;
      else if (cnt_q[i] != '0)             cnt_q[i] <= cnt_q[i] - CNT_W'(1);
    end
  end

  // Wrapping pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef TEST_RAND_DELAY_QUEUE_STATS_EN
  logic [31:0] xfers_q;
  logic [31:0] stalls_q;

  // Saturating counts of delivered messages and of cycles where the producer was refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfers_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (deq && xfers_q != 32'hFFFF_FFFF)                 xfers_q  <= xfers_q + 32'd1;
      if (in_val && !in_rdy && stalls_q != 32'hFFFF_FFFF) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_xfers  = xfers_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_xfers  = '0;
  assign stat_stalls = '0;
`endif

endmodule
